// File: rtl/tmr16.sv
// tmr16: bus-mapped 16-bit timer with prescaler and compare match.
// Periodic or one-shot operation; level IRQ and one-cycle match pulse.
module tmr16 #(
  parameter int DW = 16,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] dout,
  output logic          tmr_irq,
  output logic          tmr_pls
);

  logic          r_en;
  logic          r_ar;
  logic          r_ie;
  logic          r_if;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_cmp;
  logic [DW-1:0] r_pre;
  logic [DW-1:0] r_pcnt;
  logic [DW-1:0] r_dout;
  logic          r_pls;

  logic          w_sel_ctl;
  logic          w_sel_cnt;
  logic          w_sel_cmp;
  logic          w_sel_pre;
  logic          w_wr_ctl;
  logic          w_wr_cnt;
  logic          w_tick;
  logic          w_match;
  logic          w_en_rise;
  logic [DW-1:0] w_ctl;
  logic [DW-1:0] w_rdata;
  logic          w_unused;

  assign w_sel_ctl = (addr[11:0] == 12'h000);
  assign w_sel_cnt = (addr[11:0] == 12'h001);
  assign w_sel_cmp = (addr[11:0] == 12'h002);
  assign w_sel_pre = (addr[11:0] == 12'h003);
  assign w_unused  = &{1'b0, addr[AW-1:12]};

  assign w_wr_ctl  = we & w_sel_ctl;
  assign w_wr_cnt  = we & w_sel_cnt;
  assign w_en_rise = w_wr_ctl & din[0] & ~r_en;

  assign w_tick    = r_en & (r_pcnt == r_pre);
  assign w_match   = w_tick & (r_cnt == r_cmp);

  assign w_ctl = {{(DW-9){1'b0}}, r_if, 5'b0, r_ie, r_ar, r_en};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_ctl: w_rdata = w_ctl;
      w_sel_cnt: w_rdata = r_cnt;
      w_sel_cmp: w_rdata = r_cmp;
      w_sel_pre: w_rdata = r_pre;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_ar   <= 1'b0;
      r_ie   <= 1'b0;
      r_if   <= 1'b0;
      r_cnt  <= '0;
      r_cmp  <= '0;
      r_pre  <= '0;
      r_pcnt <= '0;
      r_dout <= '0;
      r_pls  <= 1'b0;
    end else begin
      r_pls <= w_match;
      if (!we)
        r_dout <= w_rdata;

      if (w_wr_cnt || w_en_rise)
        r_pcnt <= '0;
      else if (w_tick)
        r_pcnt <= '0;
      else if (r_en)
        r_pcnt <= r_pcnt + 1'b1;

      if (w_wr_cnt)
        r_cnt <= din;
      else if (w_tick)
        r_cnt <= w_match ? '0 : r_cnt + 1'b1;

      // software EN write beats the one-shot auto-clear
      if (w_wr_ctl)
        r_en <= din[0];
      else if (w_match && !r_ar)
        r_en <= 1'b0;

      if (w_wr_ctl) begin
        r_ar <= din[1];
        r_ie <= din[2];
      end

      // hardware set beats the W1C clear
      if (w_match)
        r_if <= 1'b1;
      else if (w_wr_ctl && din[8])
        r_if <= 1'b0;

      if (we && w_sel_cmp)
        r_cmp <= din;
      if (we && w_sel_pre)
        r_pre <= din;
    end
  end

  assign dout    = r_dout;
  assign tmr_irq = r_if & r_ie;
  assign tmr_pls = r_pls;

endmodule

// File: tb/tb_tmr16.sv
// tb_tmr16: vector tables, corner sequences and random traffic
// checked against a cycle model of the timer.
module tb_tmr16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [12:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        tmr_irq;
  logic        tmr_pls;

  int n_chk = 0;
  int n_pass = 0;

  tmr16 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .addr(addr),
    .we(we), .dout(dout), .tmr_irq(tmr_irq), .tmr_pls(tmr_pls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_irq;
    logic        exp_pls;
  } vec_t;

  bit          m_en, m_ar, m_ie, m_if, m_pls;
  int          m_cnt, m_cmp, m_pre, m_pc;
  logic [15:0] m_dout;

  function automatic logic [15:0] m_rd(input int a);
    case (a)
      0: return 16'(m_en + 2 * m_ar + 4 * m_ie + 256 * m_if);
      1: return 16'(m_cnt);
      2: return 16'(m_cmp);
      3: return 16'(m_pre);
      default: return 16'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_if = 0; m_pls = 0;
    m_cnt = 0; m_cmp = 0; m_pre = 0; m_pc = 0; m_dout = '0;
  endtask

  task automatic m_step(input logic w, input logic [12:0] a,
                        input logic [15:0] d);
    bit tick, match, en0;
    int ra;
    ra = int'(a[11:0]);
    en0 = m_en;
    tick = m_en && (m_pc == m_pre);
    match = tick && (m_cnt == m_cmp);
    if (!w) m_dout = m_rd(ra);
    if (tick) begin
      m_pc = 0;
      m_cnt = match ? 0 : (m_cnt + 1) % 65536;
    end else if (m_en) begin
      m_pc = (m_pc + 1) % 65536;
    end
    m_pls = match;
    if (match) begin
      m_if = 1;
      if (!m_ar) m_en = 0;
    end
    if (w) begin
      if (ra == 0) begin
        if (d[0] && !en0) m_pc = 0;
        m_en = d[0]; m_ar = d[1]; m_ie = d[2];
        if (d[8] && !match) m_if = 0;
      end else if (ra == 1) begin
        m_cnt = int'(d); m_pc = 0;
      end else if (ra == 2) begin
        m_cmp = int'(d);
      end else if (ra == 3) begin
        m_pre = int'(d);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic cyc(input logic w, input logic [12:0] a,
                     input logic [15:0] d);
    we = w; addr = a; din = d;
    @(posedge clk);
    m_step(w, a, d);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; we = 1'b0; addr = '0; din = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 13'h7, 16'h0);
  endtask

  vec_t tbl[$];
  int   seq_pre[7] = '{0, 0, 0, 1, 1, 1, 0};
  int   seq_wrap[7] = '{'hFFFE, 'hFFFF, 0, 1, 2, 0, 1};

  initial begin
    vec_t v;
    logic        rw;
    logic [12:0] ra;
    logic [15:0] rd;

    // reset reads, then a periodic run with TCMP=4 TPRE=0
    v = '{1'b0, 13'h0000, 16'h0, 16'h0, 1'b0, 1'b0};
    tbl.push_back(v);
    v.addr = 13'h0001; tbl.push_back(v);
    v.addr = 13'h0002; tbl.push_back(v);
    v.addr = 13'h0003; tbl.push_back(v);
    v.addr = 13'h0007; tbl.push_back(v);
    v.addr = 13'h1000; tbl.push_back(v);
    tbl.push_back('{1'b1, 13'h2, 16'h0004, 16'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 13'h3, 16'h0000, 16'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 13'h0, 16'h0007, 16'h0, 1'b0, 1'b0});
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{1'b0, 13'h7, 16'h0, 16'h0,
                      1'(k >= 5), 1'(k % 5 == 0)});
    tbl.push_back('{1'b0, 13'h1002, 16'h0, 16'h0004, 1'b1, 1'b0});

    reset_dut();
    chk("rst_dout", dout, 0);
    chk("rst_irq", tmr_irq, 0);
    chk("rst_pls", tmr_pls, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].addr, tbl[i].din);
      chk($sformatf("vec%0d", i), {dout, tmr_irq, tmr_pls},
          {tbl[i].exp_dout, tbl[i].exp_irq, tbl[i].exp_pls});
    end

    // prescaled periodic: TPRE=2 TCMP=1
    reset_dut();
    cyc(1, 13'h3, 16'h2);
    cyc(1, 13'h2, 16'h1);
    cyc(1, 13'h0, 16'h3);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 13'h1, 16'h0);
      if (k <= 7) chk($sformatf("pre_cnt%0d", k), dout, seq_pre[k-1]);
      chk($sformatf("pre_pls%0d", k), tmr_pls, k % 6 == 0);
    end

    // one-shot: TCMP=3 TPRE=0 IE=1
    reset_dut();
    cyc(1, 13'h2, 16'h3);
    cyc(1, 13'h3, 16'h0);
    cyc(1, 13'h0, 16'h5);
    for (int k = 1; k <= 24; k++) begin
      cyc(0, 13'h7, 16'h0);
      chk($sformatf("os_pls%0d", k), tmr_pls, k == 4);
    end
    cyc(0, 13'h0, 16'h0);
    chk("os_tctl", dout, 16'h0104);
    cyc(0, 13'h1, 16'h0);
    chk("os_tcnt", dout, 0);
    chk("os_irq", tmr_irq, 1);

    // W1C off a match clears; on the match edge the set wins
    cyc(1, 13'h0, 16'h0107);
    chk("w1c_clr_irq", tmr_irq, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 13'h7, 16'h0);
      chk($sformatf("w1c_idle%0d", k), {tmr_irq, tmr_pls}, 0);
    end
    cyc(1, 13'h0, 16'h0107);
    chk("w1c_match", {tmr_irq, tmr_pls}, 2'b11);

    // wrap: TCNT=FFFE, TCMP=2
    reset_dut();
    cyc(1, 13'h2, 16'h2);
    cyc(1, 13'h3, 16'h0);
    cyc(1, 13'h0, 16'h3);
    cyc(1, 13'h1, 16'hFFFE);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 13'h1, 16'h0);
      chk($sformatf("wrap_cnt%0d", k), dout, seq_wrap[k-1]);
      chk($sformatf("wrap_pls%0d", k), tmr_pls, k == 5);
    end

    // asynchronous reset mid-count
    reset_dut();
    cyc(1, 13'h2, 16'h1);
    cyc(1, 13'h3, 16'h0);
    cyc(1, 13'h0, 16'h7);
    repeat (3) cyc(0, 13'h7, 16'h0);
    cyc(0, 13'h2, 16'h0);
    chk("arst_pre_dout", dout, 1);
    chk("arst_pre_irq", tmr_irq, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_now", {dout, tmr_irq, tmr_pls}, 0);
    #3 rst_n = 1'b1;
    m_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 13'(k % 2), 16'h0);
      chk($sformatf("arst_after%0d", k), {dout, tmr_irq, tmr_pls}, 0);
    end

    // random traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      rw = ($urandom_range(0, 99) < 12);
      ra = 13'($urandom_range(0, 7)) | (13'($urandom_range(0, 1)) << 12);
      rd = 16'($urandom);
      if (rw) begin
        case (ra[2:0])
          3'd0: rd[0] = ($urandom_range(0, 3) != 0);
          3'd1: rd = ($urandom_range(0, 7) == 0) ? (16'hFFF8 | (rd & 16'h7))
                                                 : (rd & 16'h7);
          3'd2: rd = rd & 16'h7;
          3'd3: rd = rd & 16'h3;
          default: ;
        endcase
      end
      cyc(rw, ra, rd);
      chk($sformatf("rand%0d", i), {dout, tmr_irq, tmr_pls},
          {m_dout, m_if & m_ie, m_pls});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmr16.md
# tmr16

Bus-mapped 16-bit timer peripheral that produces periodic or one-shot interrupt requests for one channel of the interrupt manager's `intp_i[7:0]` inputs. It sits on the same data bus as the interrupt manager and other SoC peripherals (word address `addr`, write data `din`, registered read data `dout`). Its `tmr_irq` output is a level and must be routed to an interrupt channel configured for high-level (00) or rising-edge (10) trigger.

## Interface
- `DW`, 16: data bus width; all timer registers are 16 bits.
- `AW`, 13: address bus width; only the low 12 bits are decoded.
- `clk` input 1: single clock; all state is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input DW: bus write data.
- `addr` input AW: bus word address.
- `we` input 1: write enable, active high.
- `dout` output DW: registered bus read data.
- `tmr_irq` output 1: interrupt level, equal to `IF & IE`.
- `tmr_pls` output 1: one-cycle pulse on every compare match, not gated by `IE`.

## Operation
- Register map, decoded on `addr[11:0]`; `addr[12]` is ignored:
  - 0x0 TCTL:
    - [0] EN, count enable.
    - [1] AR: 1 = periodic, 0 = one-shot.
    - [2] IE, interrupt enable.
    - [8] IF, match flag. Reads as the flag; writing 1 clears it, writing 0 leaves it unchanged.
    - All other bits read 0.
  - 0x1 TCNT: current count, read/write.
  - 0x2 TCMP: compare value.
  - 0x3 TPRE: prescaler divisor minus 1.
- Bus writes:
  - `we=1` writes the addressed register at the clock edge.
  - Writes to unmapped addresses are ignored.
- Bus reads:
  - `we=0` loads `dout` with the addressed register value at the clock edge.
  - Unmapped addresses load `dout` with 0.
  - `dout` holds its value during write cycles.
- Prescaler:
  - An internal 16-bit `pre_cnt` runs only while EN=1.
  - tick = EN & (`pre_cnt == TPRE`).
  - On a tick, `pre_cnt` returns to 0; otherwise it increments.
  - Tick rate is one per TPRE+1 cycles.
- Counter, evaluated on each tick:
  - If TCNT == TCMP, a match occurs:
    - TCNT <= 0, IF <= 1, `tmr_pls` = 1 for the following cycle.
    - If AR=0, EN <= 0 as well.
  - Otherwise TCNT <= TCNT + 1, modulo 2^16. Wrapping 0xFFFF to 0 is not a match and produces no event.
- Priorities within one cycle:
  - A bus write to TCNT overrides any count update and clears `pre_cnt`.
  - A bus write to TCTL that sets EN from 0 to 1 clears `pre_cnt`.
  - A bus write to TCTL that clears EN wins over the one-shot auto-clear; the match still sets IF.
  - A hardware IF set wins over a simultaneous W1C clear.
  - Bus writes to TCMP or TPRE take effect on the next cycle's compare.
- Boundary cases:
  - TCMP=0 gives a match on every tick.
  - TPRE=0 gives a tick on every enabled cycle.
  - If TCNT > TCMP, the counter runs to 0xFFFF, wraps to 0, then counts up to the match.

## Timing
- Reset: TCTL, TCNT, TCMP, TPRE, `pre_cnt` and `dout` = 0; `tmr_irq` = 0; `tmr_pls` = 0.
- Read latency: `dout` is valid one edge after `addr` is presented with `we=0`.
- `tmr_pls` and IF both become 1 at the same edge, the one that zeroes TCNT on a match. `tmr_pls` drops after one cycle.
- `tmr_irq` is a combinational AND of registered bits, with no added latency.
- Period, AR=1: exactly (TPRE+1)·(TCMP+1) cycles between `tmr_pls` pulses.
- First match after EN is set from 0 with TCNT=0 (write at edge E0): IF sets at edge E0 + (TPRE+1)·(TCMP+1).
- `rst_n` asserted mid-count: all state clears immediately, without waiting for `clk`. Counting resumes only after software sets EN again.

## Test plan
- Reset, then read addresses 0x0–0x3 and 0x7: every read returns 0x0000; `tmr_irq` = 0 and `tmr_pls` = 0.
- Write TCMP=4, TPRE=0, then TCTL=0x0007 at edge E0: `tmr_pls` pulses at E0+5, E0+10, E0+15; `tmr_irq` rises at E0+5 and stays high.
- Write TPRE=2, TCMP=1, TCTL=0x0003: `tmr_pls` pulses every 6 cycles; TCNT reads the sequence 0,0,0,1,1,1,0 across consecutive edges.
- One-shot: TCMP=3, TPRE=0, TCTL=0x0005:
  - a single pulse at E0+4;
  - TCTL then reads 0x0104, TCNT stays 0;
  - no further pulses over 20 cycles.
- W1C: writing TCTL=0x0107 on a non-match cycle clears IF and drops `tmr_irq` the next cycle. The same write on the match edge leaves IF=1.
- Write TCNT=0xFFFE with TCMP=2, AR=1, TPRE=0, EN=1:
  - TCNT reads 0xFFFF, 0x0000, 0x0001, 0x0002, then 0;
  - the only pulse is at the 0x0002 to 0 transition.
- Assert `rst_n` low mid-count for half a cycle: all registers and outputs read 0 immediately and remain 0 after release.
